// File: rtl/lib_voq_reader_pkg.sv
// Shared packet type and VC index/onehot helpers for the VOQ read side.
// VC vectors are ordered [0:N-1]: VC 0 is the leftmost (MSB) bit.
package lib_voq_reader_pkg;

    localparam int unsigned MAX_VC = 32;

    typedef logic [0:MAX_VC-1] vc_vec_t;

    typedef struct packed {
        logic [2:0] vc;
        logic [7:0] tag;
    } packet_t;

    function automatic int unsigned ptr_width(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Callers left-align their [0:M-1] vector into vc_vec_t before converting.
    function automatic int unsigned onehot_to_idx(input vc_vec_t oh);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < MAX_VC; i++) begin
            if (oh[i]) r = r | i;
        end
        return r;
    endfunction

    function automatic vc_vec_t idx_to_onehot(input int unsigned idx);
        vc_vec_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_VC; i++) begin
            r[i] = (i == idx);
        end
        return r;
    endfunction

endpackage

// File: rtl/lib_rr_arbiter_onehot.sv
// Combinational round-robin arbiter: first set request scanning ptr, ptr+1, ... with mod-M wrap.
module lib_rr_arbiter_onehot
    import lib_voq_reader_pkg::*;
#(
    parameter int unsigned M = 5,
    localparam int unsigned PW = ptr_width(M)
) (
    input  logic [0:M-1]  req,
    input  logic [PW-1:0] ptr,
    output logic [0:M-1]  gnt
);

    logic [PW:0]   cand;
    logic [PW-1:0] sel;
    logic          found;
    vc_vec_t       oh;

    always_comb begin
        cand  = '0;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < M; k++) begin
            // ptr < M and k < M, so a single subtraction is enough to wrap
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(M)) cand = cand - (PW+1)'(M);
            if (!found && req[cand[PW-1:0]]) begin
                found = 1'b1;
                sel   = cand[PW-1:0];
            end
        end
        oh  = idx_to_onehot(32'(sel));
        gnt = found ? oh[0:M-1] : '0;
    end

endmodule

// File: rtl/lib_voq_reader.sv
// Read side of a VOQ bank: round-robin pop of one eligible VC per cycle into a
// registered output stage with ready/valid backpressure.
module lib_voq_reader
    import lib_voq_reader_pkg::*;
#(
    parameter int unsigned M         = 5,
    parameter int unsigned RESET_PTR = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce,
    input  packet_t      i_voq_data,
    input  logic [0:M-1] i_voq_data_val,
    output logic [0:M-1] o_voq_en,
    input  logic [0:M-1] i_vc_block,
    output packet_t      o_data,
    output logic         o_data_val,
    output logic [0:M-1] o_vc,
    input  logic         i_ready
);

    localparam int unsigned PW = ptr_width(M);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          load_ok;
    logic [0:M-1]  eligible;
    logic [0:M-1]  req;
    logic [0:M-1]  gnt;
    logic          grant;
    vc_vec_t       gnt_wide;
    int unsigned   gidx;

    // Reset gates the request so no VOQ pop is issued while it is held high.
    always_comb begin
        load_ok  = ce & (~o_data_val | i_ready) & ~reset;
        eligible = i_voq_data_val & ~i_vc_block;
        req      = load_ok ? eligible : '0;
    end

    lib_rr_arbiter_onehot #(.M(M)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_comb begin
        o_voq_en           = gnt;
        grant              = |gnt;
        gnt_wide           = '0;
        gnt_wide[0:M-1]    = gnt;
        gidx               = onehot_to_idx(gnt_wide);
        ptr_next           = (gidx == M - 1) ? '0 : PW'(gidx + 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_data     <= '0;
            o_data_val <= 1'b0;
            o_vc       <= '0;
            ptr        <= PW'(RESET_PTR);
        end else if (grant) begin
            o_data     <= i_voq_data;
            o_data_val <= 1'b1;
            o_vc       <= gnt;
            ptr        <= ptr_next;
        end else if (ce && o_data_val && i_ready) begin
            o_data_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lib_voq_reader.sv
// Directed bench for lib_voq_reader (M=5, RESET_PTR=0) with hand-computed grants.
module tb_lib_voq_reader;
    import lib_voq_reader_pkg::*;

    localparam int unsigned M = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         ce;
    packet_t      i_voq_data;
    logic [0:M-1] i_voq_data_val;
    logic [0:M-1] o_voq_en;
    logic [0:M-1] i_vc_block;
    packet_t      o_data;
    logic         o_data_val;
    logic [0:M-1] o_vc;
    logic         i_ready;
    logic [7:0]   head_tag;

    int checks   = 0;
    int failures = 0;

    lib_voq_reader #(.M(M), .RESET_PTR(0)) dut (
        .clk            (clk),
        .reset          (reset),
        .ce             (ce),
        .i_voq_data     (i_voq_data),
        .i_voq_data_val (i_voq_data_val),
        .o_voq_en       (o_voq_en),
        .i_vc_block     (i_vc_block),
        .o_data         (o_data),
        .o_data_val     (o_data_val),
        .o_vc           (o_vc),
        .i_ready        (i_ready)
    );

    always #5 clk = ~clk;

    // First-word fall-through VOQ: head carries the selected VC and the current tag.
    always_comb begin
        i_voq_data = '0;
        for (int i = 0; i < M; i++) begin
            if (o_voq_en[i]) i_voq_data = '{vc: 3'(i), tag: head_tag};
        end
    end

    function automatic packet_t mk(input int vc, input logic [7:0] tg);
        return '{vc: 3'(vc), tag: tg};
    endfunction

    task automatic chk_en(input string nm, input logic [0:M-1] exp);
        checks++;
        assert (o_voq_en === exp) else begin
            failures++;
            $error("FAIL %s: o_voq_en=%b expected %b", nm, o_voq_en, exp);
        end
    endtask

    task automatic chk_val(input string nm, input logic exp);
        checks++;
        assert (o_data_val === exp) else begin
            failures++;
            $error("FAIL %s: o_data_val=%b expected %b", nm, o_data_val, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [0:M-1] vc, input packet_t d);
        chk_val(nm, 1'b1);
        checks++;
        assert (o_vc === vc) else begin
            failures++;
            $error("FAIL %s: o_vc=%b expected %b", nm, o_vc, vc);
        end
        checks++;
        assert (o_data === d) else begin
            failures++;
            $error("FAIL %s: o_data=%h expected %h", nm, o_data, d);
        end
    endtask

    // Drive inputs at the falling edge, check the grant, then step past the rising edge.
    task automatic step(input logic [0:M-1] val, input logic [0:M-1] blk, input logic rdy,
                        input logic cen, input logic [7:0] tg, input logic [0:M-1] exp_en,
                        input string nm);
        @(negedge clk);
        i_voq_data_val = val;
        i_vc_block     = blk;
        i_ready        = rdy;
        ce             = cen;
        head_tag       = tg;
        #1;
        chk_en(nm, exp_en);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:M-1] rot [6];
        int           rot_vc [6];
        logic [0:M-1] blk_seq [4];
        int           blk_vc [4];

        rot     = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
        rot_vc  = '{0, 1, 2, 3, 4, 0};
        blk_seq = '{5'b00010, 5'b00001, 5'b01000, 5'b00010};
        blk_vc  = '{3, 4, 1, 3};

        reset          = 1'b1;
        ce             = 1'b0;
        i_voq_data_val = '0;
        i_vc_block     = '0;
        i_ready        = 1'b0;
        head_tag       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_val("reset_val", 1'b0);
        chk_en("reset_en", 5'b00000);
        checks++;
        assert (o_vc === 5'b00000 && o_data === '0) else begin
            failures++;
            $error("FAIL reset_regs: o_vc=%b o_data=%h expected 00000/000", o_vc, o_data);
        end
        @(negedge clk);
        reset = 1'b0;

        // Fair rotation with pointer wrap
        for (int i = 0; i < 6; i++) begin
            step(5'b11111, 5'b00000, 1'b1, 1'b1, 8'h10 + 8'(i), rot[i], "rotate_en");
            chk_out("rotate_out", rot[i], mk(rot_vc[i], 8'h10 + 8'(i)));
        end

        // Single valid VC, back-to-back with no bubbles
        for (int i = 0; i < 3; i++) begin
            step(5'b00010, 5'b00000, 1'b1, 1'b1, 8'h30 + 8'(i), 5'b00010, "vc3_en");
            chk_out("vc3_out", 5'b00010, mk(3, 8'h30 + 8'(i)));
        end

        // Backpressure: no pops, output held
        for (int i = 0; i < 4; i++) begin
            step(5'b01100, 5'b00000, 1'b0, 1'b1, 8'h38 + 8'(i), 5'b00000, "stall_en");
            chk_out("stall_hold", 5'b00010, mk(3, 8'h32));
        end
        step(5'b01100, 5'b00000, 1'b1, 1'b1, 8'h40, 5'b01000, "unstall_en");
        chk_out("unstall_out", 5'b01000, mk(1, 8'h40));

        // Blocked VCs skipped; clearing the block admits VC0 at its turn
        for (int i = 0; i < 4; i++) begin
            step(5'b11111, 5'b10100, 1'b1, 1'b1, 8'h50 + 8'(i), blk_seq[i], "block_en");
            chk_out("block_out", blk_seq[i], mk(blk_vc[i], 8'h50 + 8'(i)));
        end
        step(5'b11111, 5'b00000, 1'b1, 1'b1, 8'h54, 5'b00001, "unblock_en4");
        chk_out("unblock_out4", 5'b00001, mk(4, 8'h54));
        step(5'b11111, 5'b00000, 1'b1, 1'b1, 8'h55, 5'b10000, "unblock_en0");
        chk_out("unblock_out0", 5'b10000, mk(0, 8'h55));

        // Clock enable 1,0,1
        step(5'b00001, 5'b00000, 1'b1, 1'b1, 8'h60, 5'b00001, "ce1_en");
        chk_out("ce1_out", 5'b00001, mk(4, 8'h60));
        step(5'b00001, 5'b00000, 1'b1, 1'b0, 8'h61, 5'b00000, "ce0_en");
        chk_out("ce0_hold", 5'b00001, mk(4, 8'h60));
        step(5'b00001, 5'b00000, 1'b1, 1'b1, 8'h62, 5'b00001, "ce1b_en");
        chk_out("ce1b_out", 5'b00001, mk(4, 8'h62));
        step(5'b11111, 5'b00000, 1'b1, 1'b1, 8'h63, 5'b10000, "after_ce_en");
        chk_out("after_ce_out", 5'b10000, mk(0, 8'h63));

        // Drain with nothing to load
        step(5'b00000, 5'b00000, 1'b1, 1'b1, 8'h64, 5'b00000, "drain_en");
        chk_val("drain_val", 1'b0);

        // Reset mid-transfer
        step(5'b11111, 5'b00000, 1'b1, 1'b1, 8'h70, 5'b01000, "pre_rst_en");
        chk_out("pre_rst_out", 5'b01000, mk(1, 8'h70));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_val("midrst_val", 1'b0);
        chk_en("midrst_en", 5'b00000);
        checks++;
        assert (o_vc === 5'b00000 && o_data === '0) else begin
            failures++;
            $error("FAIL midrst_regs: o_vc=%b o_data=%h expected 00000/000", o_vc, o_data);
        end
        @(posedge clk);
        #1;
        chk_en("midrst_hold_en", 5'b00000);
        chk_val("midrst_hold_val", 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        head_tag = 8'h71;
        #1;
        chk_en("post_rst_en", 5'b10000);
        @(posedge clk);
        #1;
        chk_out("post_rst_out", 5'b10000, mk(0, 8'h71));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
